// File: rtl/barrel_shifter.sv
// barrel_shifter: rotates a 2**N-bit word right and left by a runtime amount
// through two independent log2 mux networks, then registers both results
// (1-clock latency, one operand pair per clock).
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  asynchronous active-low reset, clears both outputs
//   in            in   W  data word to rotate
//   amt           in   N  rotation amount, 0..W-1
//   right_shifted out  W  registered rotate-right of in by amt
//   left_shifted  out  W  registered rotate-left of in by amt
module barrel_shifter #(
  parameter int unsigned N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [2**N-1:0] in,
  input  logic [N-1:0]   amt,
  output logic [2**N-1:0] right_shifted,
  output logic [2**N-1:0] left_shifted
);

  localparam int unsigned W = 2 ** N;

  // Stage k output lives at index k+1; index 0 is the raw input word.
  logic [W-1:0] w_rot_r [N+1];
  logic [W-1:0] w_rot_l [N+1];

  assign w_rot_r[0] = in;
  assign w_rot_l[0] = in;

  // Stage k rotates by 2**k when amt[k] is set, otherwise passes through.
  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int unsigned SH = 2 ** k;

    assign w_rot_r[k+1] = amt[k] ? {w_rot_r[k][SH-1:0], w_rot_r[k][W-1:SH]}
                                 : w_rot_r[k];
    assign w_rot_l[k+1] = amt[k] ? {w_rot_l[k][W-SH-1:0], w_rot_l[k][W-1:W-SH]}
                                 : w_rot_l[k];
  end

  // Output register stage; no enable, reloads every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      right_shifted <= '0;
      left_shifted  <= '0;
    end else begin
      right_shifted <= w_rot_r[N];
      left_shifted  <= w_rot_l[N];
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: self-checking bench for barrel_shifter at N=3, N=4, N=1.
module tb_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in8;
  logic [2:0]  amt8;
  logic [7:0]  rs8, ls8;
  logic [15:0] in16;
  logic [3:0]  amt16;
  logic [15:0] rs16, ls16;
  logic [1:0]  in2;
  logic [0:0]  amt2;
  logic [1:0]  rs2, ls2;

  int checks;
  int errors;

  barrel_shifter #(.N(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .amt(amt8),
    .right_shifted(rs8), .left_shifted(ls8)
  );

  barrel_shifter #(.N(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in(in16), .amt(amt16),
    .right_shifted(rs16), .left_shifted(ls16)
  );

  barrel_shifter #(.N(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .amt(amt2),
    .right_shifted(rs2), .left_shifted(ls2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vin;
    logic [2:0] vamt;
    logic [7:0] exp_r;
    logic [7:0] exp_l;
  } vec_t;

  // Reference: bit i of the result is bit (i+a) mod w (right) or (i-a) mod w (left).
  function automatic logic [15:0] ref_rot(input logic [15:0] x, input int a,
                                          input int w, input bit right);
    logic [15:0] r;
    int src;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (right) src = (i + a) % w;
      else       src = ((i - a) % w + w) % w;
      r[i] = x[src];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands, clock once, sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];
  logic [7:0] cap_r[8];
  logic [7:0] cap_l[8];

  initial begin
    checks = 0;
    errors = 0;

    tbl[0]  = '{8'hD2, 3'd0, 8'hD2, 8'hD2};
    tbl[1]  = '{8'hD2, 3'd1, 8'h69, 8'hA5};
    tbl[2]  = '{8'hD2, 3'd2, 8'hB4, 8'h4B};
    tbl[3]  = '{8'hD2, 3'd3, 8'h5A, 8'h96};
    tbl[4]  = '{8'hD2, 3'd4, 8'h2D, 8'h2D};
    tbl[5]  = '{8'hD2, 3'd5, 8'h96, 8'h5A};
    tbl[6]  = '{8'hD2, 3'd6, 8'h4B, 8'hB4};
    tbl[7]  = '{8'hD2, 3'd7, 8'hA5, 8'h69};
    tbl[8]  = '{8'hF0, 3'd4, 8'h0F, 8'h0F};
    tbl[9]  = '{8'h01, 3'd1, 8'h80, 8'h02};
    tbl[10] = '{8'h80, 3'd1, 8'h40, 8'h01};
    tbl[11] = '{8'hFF, 3'd5, 8'hFF, 8'hFF};

    rst_n = 1'b1;
    in8 = 8'hD2; amt8 = 3'd3;
    in16 = 16'h8001; amt16 = 4'd15;
    in2 = 2'b01; amt2 = 1'b1;

    // Asynchronous reset with no clock edge in between.
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async_r", 16'(rs8), 16'h00);
    chk("reset_async_l", 16'(ls8), 16'h00);
    chk("reset_async_r16", rs16, 16'h0000);
    step();
    chk("reset_hold_r", 16'(rs8), 16'h00);
    chk("reset_hold_l", 16'(ls8), 16'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_release_r", 16'(rs8), 16'h5A);
    chk("reset_release_l", 16'(ls8), 16'h96);
    chk("n4_r", rs16, 16'h0003);
    chk("n4_l", ls16, 16'hC000);
    chk("n1_r", 16'(rs2), 16'h2);
    chk("n1_l", 16'(ls2), 16'h2);

    // Table: sweep, half-word swap, back-to-back pipelining.
    for (int i = 0; i < 12; i++) begin
      in8  = tbl[i].vin;
      amt8 = tbl[i].vamt;
      step();
      chk($sformatf("tbl%0d_r", i), 16'(rs8), 16'(tbl[i].exp_r));
      chk($sformatf("tbl%0d_l", i), 16'(ls8), 16'(tbl[i].exp_l));
    end

    // Mid-stream reset between edges while outputs are nonzero.
    in8 = 8'h01; amt8 = 3'd1;
    step();
    chk("pre_mid_r", 16'(rs8), 16'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_r", 16'(rs8), 16'h00);
    chk("mid_reset_l", 16'(ls8), 16'h00);
    chk("mid_reset_r16", rs16, 16'h0000);
    #1 rst_n = 1'b1;
    in8 = 8'hD2; amt8 = 3'd2;
    step();
    chk("resume_r", 16'(rs8), 16'hB4);
    chk("resume_l", 16'(ls8), 16'h4B);

    // Random operands against the reference model, plus identities.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] x;
      x = 8'($urandom);
      for (int a = 0; a < 8; a++) begin
        in8   = x;
        amt8  = 3'(a);
        in16  = 16'($urandom);
        amt16 = 4'($urandom_range(0, 15));
        in2   = 2'($urandom);
        amt2  = 1'($urandom);
        step();
        cap_r[a] = rs8;
        cap_l[a] = ls8;
        chk("rnd8_r", 16'(rs8), ref_rot(16'(x), a, 8, 1'b1));
        chk("rnd8_l", 16'(ls8), ref_rot(16'(x), a, 8, 1'b0));
        chk("rnd16_r", rs16, ref_rot(in16, int'(amt16), 16, 1'b1));
        chk("rnd16_l", ls16, ref_rot(in16, int'(amt16), 16, 1'b0));
        chk("rnd2_r", 16'(rs2), ref_rot(16'(in2), int'(amt2), 2, 1'b1));
        chk("rnd2_l", 16'(ls2), ref_rot(16'(in2), int'(amt2), 2, 1'b0));
      end
      for (int a = 0; a < 8; a++)
        chk("ident_r_eq_l", 16'(cap_r[a]), 16'(cap_l[(8 - a) % 8]));
      chk("ident_half", 16'(cap_r[4]), 16'(cap_l[4]));
      chk("ident_zero", 16'(cap_r[0]), 16'(x));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
